// File: rtl/aoc_pkg.sv
// Shared types for the accelerator output path: data width, packer FSM states and the
// FIFO entry layout used between the packer and its write-back buffer.
package aoc_pkg;

    localparam int unsigned DATA_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } packer_state_e;

    typedef struct packed {
        logic                 last;
        logic [DATA_SIZE-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ofmap_packer_if.sv
// DRAM write stream: word, address and last flag under a valid/ready handshake.
interface ofmap_packer_if #(
    parameter int unsigned ADDR_W = 12
);
    import aoc_pkg::*;

    logic                 valid;
    logic                 ready;
    logic                 last;
    logic [DATA_SIZE-1:0] data;
    logic [ADDR_W-1:0]    addr;

    modport master (output valid, data, addr, last, input ready);
    modport slave  (input valid, data, addr, last, output ready);

endinterface

// File: rtl/ofmap_fifo.sv
// Synchronous show-ahead FIFO of {last,data} entries; the head is readable while not empty,
// and the tail entry's last bit can be set after it was written.
module ofmap_fifo
    import aoc_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  fifo_entry_t     push_entry,
    input  logic            pop,
    input  logic            tag_tail,
    output fifo_entry_t     head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    fifo_entry_t       mem [DEPTH];
    logic [PtrW-1:0]   rd_q;
    logic [PtrW-1:0]   wr_q;
    logic [CntW-1:0]   cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= push_entry;
        end else if (tag_tail) begin
            mem[wr_q - PtrW'(1)].last <= 1'b1;
        end
    end

    assign head  = mem[rd_q];
    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/ofmap_packer.sv
// Packs PPU int8 results four per word (or passes 32-bit sums through) into a write-back FIFO
// feeding an addressed DRAM stream. OFMAP_PACKER_STATS_EN adds stall_cnt/word_cnt outputs.
module ofmap_packer
    import aoc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 raw_mode,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_done,
    ofmap_packer_if.master       wr,
    output logic                 busy,
    output logic                 overflow,
    output logic                 job_done
`ifdef OFMAP_PACKER_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          word_cnt
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    packer_state_e     state_q;
    logic              raw_q;
    logic [1:0]        lane_q;
    logic [23:0]       pack_q;
    logic [ADDR_W-1:0] addr_q;
    logic              overflow_q;
    logic              job_done_q;

    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              push_req, push_last, push_ok, drop, pop, tag_tail;
    logic              full, empty;
    logic [CntW-1:0]   count;
    logic              start, active, mode, take, done_here, will_empty;
    logic [1:0]        lane_next;
    logic [23:0]       pack_next;

    always_comb begin
        start     = (state_q == IDLE) && (in_valid || in_done);
        active    = (state_q == IDLE) || (state_q == RUN);
        // The start cycle already consumes data, so it must use the live mode.
        mode      = (state_q == IDLE) ? raw_mode : raw_q;
        take      = active && in_valid;
        done_here = active && in_done;
        pop       = !empty && wr.ready;

        push_req   = 1'b0;
        push_entry = '0;
        lane_next  = lane_q;
        pack_next  = pack_q;
        if (state_q == FLUSH) begin
            push_req        = 1'b1;
            push_entry.data = {8'h00, pack_q};
            lane_next       = 2'd0;
            pack_next       = '0;
        end else if (take) begin
            if (mode) begin
                push_req        = 1'b1;
                push_entry.data = in_data;
            end else if (lane_q == 2'd3) begin
                push_req        = 1'b1;
                push_entry.data = {in_data[7:0], pack_q};
                lane_next       = 2'd0;
                pack_next       = '0;
            end else begin
                lane_next                  = lane_q + 2'd1;
                pack_next[lane_q*8 +: 8]   = in_data[7:0];
            end
        end

        push_last       = (state_q == FLUSH) || (done_here && lane_next == 2'd0);
        push_entry.last = push_last;
        push_ok         = push_req && (!full || pop);
        drop            = push_req && !push_ok;
        // Done with nothing to push marks the word already queued; a dropped final word
        // hands its tag to the previous tail.
        tag_tail = (done_here && lane_next == 2'd0 && !push_req && !empty)
                 || (drop && push_last && !empty);
        will_empty = !push_ok && (empty || (count == CntW'(1) && pop));
    end

    ofmap_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_ok),
        .push_entry (push_entry),
        .pop        (pop),
        .tag_tail   (tag_tail),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            raw_q      <= 1'b0;
            lane_q     <= 2'd0;
            pack_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            lane_q     <= lane_next;
            pack_q     <= pack_next;
            if (start) begin
                raw_q      <= raw_mode;
                overflow_q <= 1'b0;
            end
            if (drop || (in_valid && !active)) overflow_q <= 1'b1;
            if (start) begin
                addr_q <= base_addr;
            end else if (pop) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE, RUN: begin
                    if (done_here) begin
                        if (lane_next != 2'd0) begin
                            state_q <= FLUSH;
                        end else if (will_empty) begin
                            state_q    <= IDLE;
                            job_done_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (start) begin
                        state_q <= RUN;
                    end
                end
                FLUSH, DRAIN: begin
                    if (will_empty) begin
                        state_q    <= IDLE;
                        job_done_q <= 1'b1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The tail tag written in this cycle is also shown when the tail is the head.
    assign wr.valid = !empty;
    assign wr.data  = empty ? '0 : head.data;
    assign wr.addr  = addr_q;
    assign wr.last  = !empty && (head.last || (tag_tail && count == CntW'(1)));
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign job_done = job_done_q;

`ifdef OFMAP_PACKER_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] word_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            stall_q <= '0;
            word_q  <= '0;
        end else begin
            if (wr.valid && !wr.ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (pop && word_q != 16'hFFFF) word_q <= word_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign word_cnt  = word_q;
`endif

endmodule

// File: tb/tb_ofmap_packer.sv
// Scoreboard bench for ofmap_packer: expected words are queued as stimulus is driven and
// compared as the DRAM side accepts them.
module tb_ofmap_packer;
    import aoc_pkg::*;

    localparam int unsigned ADDR_W = 12;

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, raw_mode, in_valid, in_done, out_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       in_data;
    logic              busy, overflow, job_done;
`ifdef OFMAP_PACKER_STATS_EN
    logic [15:0]       stall_cnt, word_cnt;
`endif

    ofmap_packer_if #(.ADDR_W(ADDR_W)) wr_if ();
    assign wr_if.ready = out_ready;

    ofmap_packer #(
        .FIFO_DEPTH (16),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_mode  (raw_mode),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_done   (in_done),
        .wr        (wr_if),
        .busy      (busy),
        .overflow  (overflow),
        .job_done  (job_done)
`ifdef OFMAP_PACKER_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   jd_cnt = 0;
    int   stall_seen = 0;
    bit   rand_ready = 1'b0;
    exp_t exp_q[$];
    exp_t e_mon;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (job_done) jd_cnt++;
            if (wr_if.valid && !out_ready) stall_seen++;
            if (wr_if.valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_data", 64'(wr_if.data), 64'(e_mon.data));
                    check("out_addr", 64'(wr_if.addr), 64'(e_mon.addr));
                    check("out_last", 64'(wr_if.last), 64'(e_mon.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic done);
        in_valid = 1'b1;
        in_data  = d;
        in_done  = done;
        tick();
        in_valid = 1'b0;
        in_done  = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_done();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [ADDR_W-1:0] a, input logic l);
        exp_t e;
        e.data = d;
        e.addr = a;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_job(input string tag, input int budget);
        int start_cnt = jd_cnt;
        int n = 0;
        while (jd_cnt == start_cnt && n < budget) begin
            tick();
            n++;
        end
        check({tag, " job_done"}, 64'(jd_cnt - start_cnt), 64'd1);
        check({tag, " drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; raw_mode = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_done = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst out_valid", 64'(wr_if.valid), 64'd0);
        check("rst out_data", 64'(wr_if.data), 64'd0);
        check("rst out_addr", 64'(wr_if.addr), 64'd0);
        check("rst out_last", 64'(wr_if.last), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst job_done", 64'(job_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: two packed words, done right after the last byte
        raw_mode = 1'b0; base_addr = 12'h100; out_ready = 1'b1;
        expect_word(32'h04030201, 12'h100, 1'b0);
        expect_word(32'h08070605, 12'h101, 1'b1);
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        pulse_done();
        wait_job("T1", 20);
        check("T1 overflow", 64'(overflow), 64'd0);

        // T2: partial final word is zero padded
        base_addr = 12'h200;
        expect_word(32'hA3A2A1A0, 12'h200, 1'b0);
        expect_word(32'h000000A4, 12'h201, 1'b1);
        for (int i = 0; i < 5; i++) send(32'hA0 + 32'(i), 1'b0);
        pulse_done();
        wait_job("T2", 20);

        // T3: passthrough with address wrap
        raw_mode = 1'b1; base_addr = 12'hFFE;
        expect_word(32'hDEADBEEF, 12'hFFE, 1'b0);
        expect_word(32'h00000001, 12'hFFF, 1'b0);
        expect_word(32'hFFFFFFFF, 12'h000, 1'b1);
        send(32'hDEADBEEF, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        wait_job("T3", 20);

        // T4: overflow with the final word dropped; tag moves to word 16
        base_addr = 12'h040; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) expect_word(32'h1000 + 32'(i), 12'h040 + 12'(i), i == 15);
        for (int i = 0; i < 17; i++) send(32'h1000 + 32'(i), i == 16);
        @(negedge clk);
        check("T4 overflow", 64'(overflow), 64'd1);
        check("T4 held valid", 64'(wr_if.valid), 64'd1);
        check("T4 held data", 64'(wr_if.data), 64'h1000);
        check("T4 busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_job("T4", 40);

        // T5: done with the 4th byte gives no pad word
        raw_mode = 1'b0; base_addr = 12'h300;
        expect_word(32'h44332211, 12'h300, 1'b1);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        send(32'h44, 1'b1);
        wait_job("T5", 20);
        check("T5 overflow cleared", 64'(overflow), 64'd0);

        // T5b: reset in the middle of a job
        raw_mode = 1'b1; out_ready = 1'b0;
        send(32'hAAAA, 1'b0);
        send(32'hBBBB, 1'b0);
        check("T5 busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("T5 rst out_valid", 64'(wr_if.valid), 64'd0);
        check("T5 rst out_data", 64'(wr_if.data), 64'd0);
        check("T5 rst out_addr", 64'(wr_if.addr), 64'd0);
        check("T5 rst out_last", 64'(wr_if.last), 64'd0);
        check("T5 rst busy", 64'(busy), 64'd0);
        check("T5 rst overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T6: done with no data
        out_ready = 1'b1; raw_mode = 1'b0; base_addr = 12'h010;
        in_done = 1'b1;
        @(negedge clk);
        check("T6 no valid at done", 64'(wr_if.valid), 64'd0);
        check("T6 job_done not yet", 64'(job_done), 64'd0);
        @(posedge clk);
        #1;
        in_done = 1'b0;
        @(negedge clk);
        check("T6 job_done", 64'(job_done), 64'd1);
        check("T6 no valid", 64'(wr_if.valid), 64'd0);
        @(posedge clk);
        #1;

`ifdef OFMAP_PACKER_STATS_EN
        // Stats: random backpressure, counters compared with observed stalls
        raw_mode = 1'b1; base_addr = 12'h020;
        for (int i = 0; i < 10; i++) expect_word(32'h5000 + 32'(i), 12'h020 + 12'(i), i == 9);
        stall_seen = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h5000 + 32'(i), i == 9);
        wait_job("STATS", 200);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        check("STATS stall_cnt", 64'(stall_cnt), 64'(stall_seen));
        check("STATS word_cnt", 64'(word_cnt), 64'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
